elevator_car_ctrl: RTL



---
 rtl/elevator_car_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/elevator_car_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | elevator_car_ctrl: accepts floor requests (valid/ready), steps the car    |
// | one floor per STEP_CYCLES, then holds the door. Macro: DOOR_REOPEN_EN.    |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module elevator_car_ctrl #(
  parameter int FLOOR_W     = 3,
  parameter int NUM_FLOORS  = 8,
  parameter int STEP_CYCLES = 50000000,
  parameter int DOOR_CYCLES = 100000000
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [FLOOR_W-1:0] req_floor,
  input  logic               req_valid,
`ifdef DOOR_REOPEN_EN
  input  logic               door_btn,
`endif
  output logic               req_ready,
  output logic [FLOOR_W-1:0] cur_floor,
  output logic               dir_up,
  output logic               dir_down,
  output logic               door_open,
  output logic               arrived
);

  localparam int C_CNT_MAX = (STEP_CYCLES > DOOR_CYCLES) ? STEP_CYCLES : DOOR_CYCLES;
  localparam int C_CNT_W   = $clog2(C_CNT_MAX + 1);
  localparam logic [C_CNT_W-1:0] C_STEP_LAST = C_CNT_W'(STEP_CYCLES - 1);
  localparam logic [C_CNT_W-1:0] C_DOOR_LAST = C_CNT_W'(DOOR_CYCLES - 1);
  localparam logic [FLOOR_W:0]   C_NUM_FLOORS = (FLOOR_W + 1)'(NUM_FLOORS);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_MOVE_UP   = 2'd1,
    S_MOVE_DOWN = 2'd2,
    S_DOOR      = 2'd3
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [C_CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [FLOOR_W-1:0]   r_floor, w_floor_nxt;
  logic [FLOOR_W-1:0]   r_target, w_target_nxt;
  logic                 r_arrived, w_arrived_nxt;
  logic                 w_accept;
  logic                 w_in_range;
  logic [FLOOR_W-1:0]   w_floor_adj;

  assign w_accept    = req_valid && (r_state == S_IDLE);
  assign w_in_range  = ({1'b0, req_floor} < C_NUM_FLOORS);
  assign w_floor_adj = (r_state == S_MOVE_UP) ? (r_floor + FLOOR_W'(1))
                                              : (r_floor - FLOOR_W'(1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_floor   <= '0;
      r_target  <= '0;
      r_arrived <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_floor   <= w_floor_nxt;
      r_target  <= w_target_nxt;
      r_arrived <= w_arrived_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_floor_nxt   = r_floor;
    w_target_nxt  = r_target;
    w_arrived_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          // Out-of-range requests are consumed silently and leave the car idle.
          w_target_nxt = req_floor;
          w_cnt_nxt    = '0;
          if (!w_in_range) begin
            w_state_nxt = S_IDLE;
          end else if (req_floor == r_floor) begin
            w_state_nxt   = S_DOOR;
            w_arrived_nxt = 1'b1;
          end else if (req_floor > r_floor) begin
            w_state_nxt = S_MOVE_UP;
          end else begin
            w_state_nxt = S_MOVE_DOWN;
          end
        end
`ifdef DOOR_REOPEN_EN
        else if (door_btn) begin
          w_state_nxt = S_DOOR;
          w_cnt_nxt   = '0;
        end
`endif
      end
      S_MOVE_UP, S_MOVE_DOWN: begin
        if (r_cnt == C_STEP_LAST) begin
          w_cnt_nxt   = '0;
          w_floor_nxt = w_floor_adj;
          if (w_floor_adj == r_target) begin
            w_state_nxt   = S_DOOR;
            w_arrived_nxt = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + C_CNT_W'(1);
        end
      end
      S_DOOR: begin
`ifdef DOOR_REOPEN_EN
        if (door_btn) begin
          w_cnt_nxt = '0;
        end else
`endif
        if (r_cnt == C_DOOR_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + C_CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign req_ready = (r_state == S_IDLE);
  assign dir_up    = (r_state == S_MOVE_UP);
  assign dir_down  = (r_state == S_MOVE_DOWN);
  assign door_open = (r_state == S_DOOR);
  assign cur_floor = r_floor;
  assign arrived   = r_arrived;

endmodule
`default_nettype wire
